// File: rtl/pll_ctrl_pkg.sv
// Shared types and widths for the PLL LMMI control slice.
package pll_ctrl_pkg;

  localparam int LMMI_OFFSET_W = 7;
  localparam int LMMI_DATA_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCESS   = 3'd1,
    ST_RDWAIT   = 3'd2,
    ST_RESP     = 3'd3,
    ST_PLLRST   = 3'd4,
    ST_LOCKWAIT = 3'd5
  } pll_lmmi_state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lmmi_ctrl_if.sv
// Register request/response bus plus the LMMI port of the PLL.
// slave = controller view, master = system/PLL side.
interface pll_lmmi_ctrl_if;

  logic                                   req_valid_i;
  logic                                   req_ready_o;
  logic                                   req_write_i;
  logic [pll_ctrl_pkg::LMMI_OFFSET_W-1:0] req_addr_i;
  logic [pll_ctrl_pkg::LMMI_DATA_W-1:0]   req_wdata_i;
  logic                                   rsp_valid_o;
  logic [pll_ctrl_pkg::LMMI_DATA_W-1:0]   rsp_rdata_o;
  logic                                   rsp_err_o;

  logic                                   lmmi_request_o;
  logic                                   lmmi_wrrd_n_o;
  logic [pll_ctrl_pkg::LMMI_OFFSET_W-1:0] lmmi_offset_o;
  logic [pll_ctrl_pkg::LMMI_DATA_W-1:0]   lmmi_wdata_o;
  logic [pll_ctrl_pkg::LMMI_DATA_W-1:0]   lmmi_rdata_i;
  logic                                   lmmi_rdatavalid_i;
  logic                                   lmmi_ready_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
           lmmi_rdata_i, lmmi_rdatavalid_i, lmmi_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           lmmi_request_o, lmmi_wrrd_n_o, lmmi_offset_o, lmmi_wdata_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
           lmmi_rdata_i, lmmi_rdatavalid_i, lmmi_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           lmmi_request_o, lmmi_wrrd_n_o, lmmi_offset_o, lmmi_wdata_o
  );

endinterface

// File: rtl/pll_lmmi_ctrl_sync2.sv
// Generic two-flop synchronizer, asynchronously cleared to 0.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: flops use non-blocking <= so every stage samples the pre-edge value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lmmi_ctrl.sv
// Register-request to LMMI bridge with PLL reset/relock sequencing and lock qualification.
// Define PLL_LMMI_CTRL_TIMEOUT_EN to enable the access and lock timeouts.
module pll_lmmi_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned TIMEOUT      = 1023,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pll_lmmi_ctrl_if.slave        bus,
  input  logic                  relock_i,
  output logic                  busy_o,
  output logic                  locked_o,
  output logic                  lock_err_o,
  input  logic                  pll_lock_i,
  output logic                  pll_reset_o
);

  if (RST_CYCLES == 0 || TIMEOUT == 0 || LOCK_TIMEOUT == 0) begin : g_bad_cfg
    $error("pll_lmmi_ctrl: RST_CYCLES, TIMEOUT and LOCK_TIMEOUT must all be >= 1");
  end

`ifdef PLL_LMMI_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_MAX = max3(TIMEOUT, RST_CYCLES, LOCK_TIMEOUT);
`else
  localparam int unsigned CNT_MAX = RST_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_SAT = '1;
  localparam cnt_t RST_LIM = cnt_t'(RST_CYCLES);
`ifdef PLL_LMMI_CTRL_TIMEOUT_EN
  // The counter holds "cycles since accept"; firing at TIMEOUT-1 lands the
  // error response exactly TIMEOUT cycles after the accept.
  localparam cnt_t TO_LIM   = cnt_t'(TIMEOUT - 1);
  localparam cnt_t LOCK_LIM = cnt_t'(LOCK_TIMEOUT);
`endif

  pll_lmmi_state_e            state_q, state_d;
  cnt_t                       cnt_q, cnt_d, cnt_inc;
  logic                       write_q, write_d;
  logic [LMMI_OFFSET_W-1:0]   addr_q, addr_d;
  logic [LMMI_DATA_W-1:0]     wdata_q, wdata_d;
  logic [LMMI_DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                       rsp_err_q, rsp_err_d;
  logic                       lock_err_q, lock_err_d;
  logic                       live_q;
  logic                       lock_sync;
  logic                       req_ready;
  logic                       accept;
  logic                       access_to;

  sync2 u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_lock_i),
    .q_o   (lock_sync)
  );

  // live_q keeps req_ready_o low while reset is applied and for one cycle after.
  assign req_ready = live_q & (state_q == ST_IDLE) & ~relock_i;
  assign accept    = req_ready & bus.req_valid_i;
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + cnt_t'(1);

`ifdef PLL_LMMI_CTRL_TIMEOUT_EN
  assign access_to = (cnt_q >= TO_LIM);
`else
  assign access_to = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    lock_err_d  = lock_err_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_t'(1);
        if (live_q && relock_i) begin
          state_d    = ST_PLLRST;
          lock_err_d = 1'b0;
        end else if (accept) begin
          state_d = ST_ACCESS;
          write_d = bus.req_write_i;
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
        end
      end

      ST_ACCESS: begin
        if (bus.lmmi_ready_i) begin
          if (write_q) begin
            state_d     = ST_RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
          end else if (bus.lmmi_rdatavalid_i) begin
            state_d     = ST_RESP;
            rsp_rdata_d = bus.lmmi_rdata_i;
            rsp_err_d   = 1'b0;
          end else begin
            state_d = ST_RDWAIT;
          end
        end else if (access_to) begin
          state_d     = ST_RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end

      ST_RDWAIT: begin
        if (bus.lmmi_rdatavalid_i) begin
          state_d     = ST_RESP;
          rsp_rdata_d = bus.lmmi_rdata_i;
          rsp_err_d   = 1'b0;
        end else if (access_to) begin
          state_d     = ST_RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      ST_PLLRST: begin
        if (cnt_q >= RST_LIM) begin
          state_d = ST_LOCKWAIT;
          cnt_d   = cnt_t'(1);
        end
      end

      ST_LOCKWAIT: begin
        if (lock_sync) begin
          state_d = ST_IDLE;
        end
`ifdef PLL_LMMI_CTRL_TIMEOUT_EN
        else if (cnt_q >= LOCK_LIM) begin
          state_d    = ST_IDLE;
          lock_err_d = 1'b1;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      lock_err_q  <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      lock_err_q  <= lock_err_d;
      live_q      <= 1'b1;
    end
  end

  assign bus.req_ready_o    = req_ready;
  assign bus.rsp_valid_o    = (state_q == ST_RESP);
  assign bus.rsp_rdata_o    = rsp_rdata_q;
  assign bus.rsp_err_o      = rsp_err_q;
  assign bus.lmmi_request_o = (state_q == ST_ACCESS);
  assign bus.lmmi_wrrd_n_o  = write_q;
  assign bus.lmmi_offset_o  = addr_q;
  assign bus.lmmi_wdata_o   = wdata_q;

  assign busy_o      = (state_q != ST_IDLE);
  assign pll_reset_o = (state_q == ST_PLLRST);
  assign locked_o    = lock_sync & (state_q != ST_PLLRST) & (state_q != ST_LOCKWAIT);
  assign lock_err_o  = lock_err_q;

endmodule
